// File: rtl/hex_count_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : hex_count_sequencer
// Description : Sequencer for a 4-bit up/down hex counter. Runs up, down,
//               ping-pong or wrap sequences between latched bounds Lo..Hi.
//               An internal prescaler paces one step every TICK_DIV clocks.
//               The counter value is read back to decide turnarounds and
//               termination.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   Clk         in   1  system clock, rising edge
//   Reset       in   1  asynchronous active-high reset
//   Start       in   1  start a new sequence (IDLE/DONE) or resume (HOLD)
//   Stop        in   1  pause a running sequence; wins over Start
//   Mode        in   2  00 up, 01 down, 10 ping-pong, 11 wrap-up
//   Lo, Hi      in   4  sequence bounds, latched at Start
//   Count_value in   4  counter output fed back
//   Load        out  1  counter parallel-load strobe
//   Count_in    out  4  counter parallel-load value
//   Count_en    out  1  counter enable, one pulse per step
//   Up          out  1  counter direction (1 = up)
//   Busy        out  1  sequence in LOAD, RUN or HOLD
//   Done        out  1  single sweep finished
//   Err         out  1  last Start had Lo > Hi
// ============================================================================
module hex_count_sequencer #(
    parameter int TICK_DIV = 4,
    parameter int DIV_W    = 24
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Stop,
    input  logic [1:0] Mode,
    input  logic [3:0] Lo,
    input  logic [3:0] Hi,
    input  logic [3:0] Count_value,
    output logic       Load,
    output logic [3:0] Count_in,
    output logic       Count_en,
    output logic       Up,
    output logic       Busy,
    output logic       Done,
    output logic       Err
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_HOLD = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [DIV_W-1:0] c_TICK_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] c_ONE       = DIV_W'(1);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic             dir_q, dir_d;       // ping-pong direction, 1 = up
    logic [1:0]       mode_q, mode_d;
    logic [3:0]       lo_q, lo_d;
    logic [3:0]       hi_q, hi_d;
    logic             load_q, load_d;
    logic [3:0]       count_in_q, count_in_d;
    logic             count_en_q, count_en_d;
    logic             up_q, up_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             w_tick;

    assign w_tick = (presc_q == c_TICK_LAST);

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        dir_d      = dir_q;
        mode_d     = mode_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        load_d     = 1'b0;
        count_in_d = count_in_q;
        count_en_d = 1'b0;
        up_d       = up_q;
        err_d      = err_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Start && !Stop) begin
                    mode_d = Mode;
                    lo_d   = Lo;
                    hi_d   = Hi;
                    if (Lo > Hi) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        // Outputs are registered, so the load strobe is set
                        // on entry and is visible for the whole LOAD cycle.
                        err_d      = 1'b0;
                        state_d    = ST_LOAD;
                        load_d     = 1'b1;
                        count_in_d = (Mode == 2'b01) ? Hi : Lo;
                        up_d       = (Mode != 2'b01);
                        dir_d      = (Mode != 2'b01);
                        presc_d    = '0;
                    end
                end
            end

            ST_LOAD: begin
                state_d = ST_RUN;
                presc_d = '0;
            end

            ST_RUN: begin
                if (Stop) begin
                    // Prescaler frozen: resume finishes the interrupted interval.
                    state_d = ST_HOLD;
                end else begin
                    presc_d = w_tick ? '0 : presc_q + c_ONE;
                    if (w_tick) begin
                        case (mode_q)
                            2'b00: begin
                                if (Count_value == hi_q) begin
                                    state_d = ST_DONE;
                                end else begin
                                    count_en_d = 1'b1;
                                    up_d       = 1'b1;
                                end
                            end
                            2'b01: begin
                                if (Count_value == lo_q) begin
                                    state_d = ST_DONE;
                                end else begin
                                    count_en_d = 1'b1;
                                    up_d       = 1'b0;
                                end
                            end
                            2'b10: begin
                                // Turnaround also steps; a one-value range never moves.
                                if (dir_q) begin
                                    if (Count_value == hi_q) begin
                                        if (lo_q != hi_q) begin
                                            dir_d      = 1'b0;
                                            count_en_d = 1'b1;
                                            up_d       = 1'b0;
                                        end
                                    end else begin
                                        count_en_d = 1'b1;
                                        up_d       = 1'b1;
                                    end
                                end else begin
                                    if (Count_value == lo_q) begin
                                        if (lo_q != hi_q) begin
                                            dir_d      = 1'b1;
                                            count_en_d = 1'b1;
                                            up_d       = 1'b1;
                                        end
                                    end else begin
                                        count_en_d = 1'b1;
                                        up_d       = 1'b0;
                                    end
                                end
                            end
                            default: begin
                                // Wrap uses a reload rather than a count step.
                                if (Count_value == hi_q) begin
                                    load_d     = 1'b1;
                                    count_in_d = lo_q;
                                end else begin
                                    count_en_d = 1'b1;
                                    up_d       = 1'b1;
                                end
                            end
                        endcase
                    end
                end
            end

            ST_HOLD: begin
                if (Start && !Stop) begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_LOAD) || (state_d == ST_RUN) || (state_d == ST_HOLD);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            dir_q      <= 1'b1;
            mode_q     <= 2'b00;
            lo_q       <= 4'h0;
            hi_q       <= 4'h0;
            load_q     <= 1'b0;
            count_in_q <= 4'h0;
            count_en_q <= 1'b0;
            up_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            dir_q      <= dir_d;
            mode_q     <= mode_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            load_q     <= load_d;
            count_in_q <= count_in_d;
            count_en_q <= count_en_d;
            up_q       <= up_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign Load     = load_q;
    assign Count_in = count_in_q;
    assign Count_en = count_en_q;
    assign Up       = up_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_count_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_hex_count_sequencer
// Description : Directed self-checking bench for hex_count_sequencer, with a
//               behavioural 4-bit up/down counter closing the feedback loop.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_count_sequencer;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic       stop  = 1'b0;
    logic [1:0] mode  = 2'b00;
    logic [3:0] lo    = 4'h0;
    logic [3:0] hi    = 4'h0;
    logic [3:0] cnt   = 4'h0;
    logic       load, count_en, up, busy, done, err;
    logic [3:0] count_in;

    int checks = 0;
    int errors = 0;

    logic [3:0] pp_val [10] = '{4'd1, 4'd2, 4'd1, 4'd0, 4'd1, 4'd2, 4'd1, 4'd0, 4'd1, 4'd2};
    logic       pp_up  [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    always #5 clk = ~clk;

    hex_count_sequencer #(.TICK_DIV(4), .DIV_W(24)) dut (
        .Clk(clk), .Reset(rst), .Start(start), .Stop(stop), .Mode(mode),
        .Lo(lo), .Hi(hi), .Count_value(cnt), .Load(load), .Count_in(count_in),
        .Count_en(count_en), .Up(up), .Busy(busy), .Done(done), .Err(err)
    );

    // External counter: not reset by the sequencer's Reset.
    always @(posedge clk) begin
        if (load)          cnt <= count_in;
        else if (count_en) cnt <= up ? cnt + 4'd1 : cnt - 4'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_strobe(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(load || count_en) && n < 40);
    endtask

    task automatic wait_done(output int n, output int strobes);
        n = 0;
        strobes = 0;
        do begin
            @(negedge clk);
            n++;
            if (load || count_en) strobes++;
        end while (!done && n < 40);
    endtask

    // Waits for the next strobe, checks its spacing and kind, then the counter.
    task automatic step_chk(input string tag, input int exp_n, input logic exp_ld,
                            input logic exp_en, input logic exp_up, input logic [3:0] exp_cnt);
        int n;
        wait_strobe(n);
        chk({tag, "_gap"}, n, exp_n);
        chk({tag, "_load"}, load, exp_ld);
        chk({tag, "_en"}, count_en, exp_en);
        chk({tag, "_up"}, up, exp_up);
        @(negedge clk);
        chk({tag, "_cnt"}, cnt, exp_cnt);
    endtask

    task automatic start_seq(input logic [1:0] m, input logic [3:0] l, input logic [3:0] h);
        mode  = m;
        lo    = l;
        hi    = h;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int n, s, strb;

        // Reset state
        @(negedge clk);
        chk("rst_load", load, 1'b0);
        chk("rst_cin", count_in, 4'h0);
        chk("rst_en", count_en, 1'b0);
        chk("rst_up", up, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Single up sweep 3..6
        start_seq(2'b00, 4'd3, 4'd6);
        chk("up_load", load, 1'b1);
        chk("up_cin", count_in, 4'd3);
        chk("up_upbit", up, 1'b1);
        chk("up_en0", count_en, 1'b0);
        chk("up_busy", busy, 1'b1);
        @(negedge clk);
        chk("up_cnt0", cnt, 4'd3);
        step_chk("up_s1", 4, 1'b0, 1'b1, 1'b1, 4'd4);
        step_chk("up_s2", 3, 1'b0, 1'b1, 1'b1, 4'd5);
        step_chk("up_s3", 3, 1'b0, 1'b1, 1'b1, 4'd6);
        wait_done(n, s);
        chk("up_done_gap", n, 3);
        chk("up_done_strb", s, 0);
        chk("up_done", done, 1'b1);
        chk("up_busy_end", busy, 1'b0);

        // Single down sweep 5..2
        start_seq(2'b01, 4'd2, 4'd5);
        chk("dn_load", load, 1'b1);
        chk("dn_cin", count_in, 4'd5);
        chk("dn_upbit", up, 1'b0);
        chk("dn_done_clr", done, 1'b0);
        @(negedge clk);
        chk("dn_cnt0", cnt, 4'd5);
        step_chk("dn_s1", 4, 1'b0, 1'b1, 1'b0, 4'd4);
        step_chk("dn_s2", 3, 1'b0, 1'b1, 1'b0, 4'd3);
        step_chk("dn_s3", 3, 1'b0, 1'b1, 1'b0, 4'd2);
        wait_done(n, s);
        chk("dn_done_gap", n, 3);
        chk("dn_done_strb", s, 0);
        chk("dn_done", done, 1'b1);

        // Ping-pong 0..2 for 10 steps
        start_seq(2'b10, 4'd0, 4'd2);
        chk("pp_load", load, 1'b1);
        chk("pp_cin", count_in, 4'd0);
        chk("pp_upbit", up, 1'b1);
        @(negedge clk);
        chk("pp_cnt0", cnt, 4'd0);
        for (int i = 0; i < 10; i++) begin
            step_chk($sformatf("pp_s%0d", i), (i == 0) ? 4 : 3, 1'b0, 1'b1, pp_up[i], pp_val[i]);
        end
        chk("pp_done", done, 1'b0);
        chk("pp_busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Wrap-up E..F: wrap step reloads instead of counting
        start_seq(2'b11, 4'hE, 4'hF);
        chk("wr_load", load, 1'b1);
        chk("wr_cin", count_in, 4'hE);
        @(negedge clk);
        chk("wr_cnt0", cnt, 4'hE);
        step_chk("wr_s1", 4, 1'b0, 1'b1, 1'b1, 4'hF);
        step_chk("wr_s2", 3, 1'b1, 1'b0, 1'b1, 4'hE);
        step_chk("wr_s3", 3, 1'b0, 1'b1, 1'b1, 4'hF);
        step_chk("wr_s4", 3, 1'b1, 1'b0, 1'b1, 4'hE);
        chk("wr_busy", busy, 1'b1);

        // Asynchronous reset mid-RUN, sampled before any clock edge
        rst = 1'b1;
        #1;
        chk("ar_busy", busy, 1'b0);
        chk("ar_cin", count_in, 4'h0);
        chk("ar_load", load, 1'b0);
        chk("ar_en", count_en, 1'b0);
        chk("ar_up", up, 1'b1);
        chk("ar_done", done, 1'b0);
        chk("ar_err", err, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Stop / hold / resume in mode 00, 0..9
        start_seq(2'b00, 4'd0, 4'd9);
        @(negedge clk);
        chk("hd_cnt0", cnt, 4'd0);
        step_chk("hd_s1", 4, 1'b0, 1'b1, 1'b1, 4'd1);
        step_chk("hd_s2", 3, 1'b0, 1'b1, 1'b1, 4'd2);
        stop = 1'b1;
        strb = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) start = 1'b1;   // Start with Stop: must stay held
            @(negedge clk);
            if (load || count_en) strb++;
        end
        chk("hd_strobes", strb, 0);
        chk("hd_busy", busy, 1'b1);
        chk("hd_done", done, 1'b0);
        stop  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        step_chk("hd_resume", 3, 1'b0, 1'b1, 1'b1, 4'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Bounds error, then recovery with Lo == Hi
        start_seq(2'b00, 4'd7, 4'd3);
        chk("er_err", err, 1'b1);
        chk("er_load", load, 1'b0);
        chk("er_busy", busy, 1'b0);
        @(negedge clk);
        chk("er_idle_load", load, 1'b0);
        chk("er_idle_busy", busy, 1'b0);
        chk("er_hold", err, 1'b1);
        start_seq(2'b00, 4'd5, 4'd5);
        chk("eq_load", load, 1'b1);
        chk("eq_err_clr", err, 1'b0);
        chk("eq_cin", count_in, 4'd5);
        @(negedge clk);
        wait_done(n, s);
        chk("eq_done_gap", n, 4);
        chk("eq_done_strb", s, 0);
        chk("eq_done", done, 1'b1);
        chk("eq_cnt", cnt, 4'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hex_count_sequencer.md
Name: hex_count_sequencer

Overview:
Controller that sequences the 4-bit up/down hex counter (Load, Count_en, Up, Count_in) feeding the hex 7-segment digit. Runs programmable count sequences between a latched low bound and high bound: single up sweep, single down sweep, continuous ping-pong, or continuous wrap. Steps are paced by an internal tick prescaler, so the counter runs at a visible rate from the system clock. It reads the counter's current value back to decide turnarounds and termination.

Parameters:
TICK_DIV, 4, Clk cycles per count step (>=2).
DIV_W, 24, prescaler width; must satisfy 2^DIV_W >= TICK_DIV.

Ports:
Clk  input  1  system clock, rising edge.
Reset  input  1  asynchronous, active-high reset.
Start  input  1  level-sampled command: begin a new sequence, or resume from HOLD.
Stop  input  1  level-sampled command: pause a running sequence.
Mode  input  2  00 single up, 01 single down, 10 ping-pong, 11 wrap-up; latched at Start.
Lo  input  4  low bound; latched at Start.
Hi  input  4  high bound; latched at Start.
Count_value  input  4  counter output, fed back.
Load  output  1  counter parallel-load strobe.
Count_in  output  4  counter parallel-load value.
Count_en  output  1  counter count enable, one-cycle pulse per step.
Up  output  1  counter direction, 1 = up.
Busy  output  1  high in LOAD, RUN and HOLD.
Done  output  1  high in DONE.
Err  output  1  bounds error flag.

Behaviour:
- All outputs are registered. Reset (async, Reset=1) clears everything:
  - state=IDLE, prescaler=0, direction register=up.
  - Load=0, Count_in=0, Count_en=0, Up=1, Busy=0, Done=0, Err=0.
- States: IDLE, LOAD, RUN, HOLD, DONE.
- IDLE or DONE with Start=1 and Stop=0:
  - Latch Mode, Lo and Hi.
  - If Lo>Hi: Err=1, go to IDLE, no Load.
  - Otherwise: Err=0, Done=0, go to LOAD.
- LOAD lasts exactly 1 cycle, then goes to RUN:
  - Load=1.
  - Count_in=Hi in mode 01, Lo in all other modes.
  - Up=0 in mode 01, 1 in all other modes.
  - Direction register set to match Up.
  - Prescaler cleared.
- RUN:
  - Prescaler increments each cycle.
  - tick=1 when prescaler==TICK_DIV-1; prescaler then returns to 0.
  - First tick comes TICK_DIV cycles after LOAD.
  - Count_en, and any Load in RUN, assert only in the cycle following a tick, for 1 cycle. Up is held stable throughout.
- Step action on tick, using the Count_value sampled in the tick cycle (v):
  - Mode 00: v==Hi -> DONE. Else Count_en=1, Up=1.
  - Mode 01: v==Lo -> DONE. Else Count_en=1, Up=0.
  - Mode 10, direction up:
    - v==Hi and Lo!=Hi: flip direction, Count_en=1, Up=0 (the turnaround also steps).
    - v==Hi and Lo==Hi: no step.
    - Otherwise: Count_en=1, Up=1.
  - Mode 10, direction down: symmetric at Lo.
  - Mode 11: v==Hi -> Load=1, Count_in=Lo. Else Count_en=1, Up=1.
  - Modes 10 and 11 never reach DONE; only Stop or Reset ends them.
- Stop=1 in RUN:
  - Go to HOLD next cycle; suppress any step pending that cycle.
  - Prescaler value and direction register retained.
- HOLD:
  - No strobes; Busy=1.
  - Start=1 and Stop=0 -> RUN, prescaler continues from its retained value.
  - Lo, Hi and Mode are not re-latched.
- Simultaneous Start and Stop: Stop wins in every state; Start is ignored.
- DONE: Done=1 and held until Start or Reset; Busy=0.
- Load and Count_en are never high in the same cycle.
- Reset mid-sequence:
  - Immediate return to reset values.
  - The counter itself is not touched; the next Start reloads it.
- Start held high through a whole sequence re-triggers from DONE on the next cycle, which gives repetition; this is intended.

Test Plan:
- TICK_DIV=4, Mode=00, Lo=3, Hi=6, 1-cycle Start -> Load pulse with Count_in=3; Count_en pulses every 4 cycles; counter shows 3,4,5,6; Done=1 on the tick after value 6; Busy=0.
- Mode=01, Lo=2, Hi=5 -> Count_in=5, Up=0; counter shows 5,4,3,2; then Done=1.
- Mode=10, Lo=0, Hi=2, run 10 ticks -> counter shows 0,1,2,1,0,1,2,1,0,1,2; Up flips in the same step as the turnaround; Done stays 0.
- Mode=11, Lo=0xE, Hi=0xF -> E,F,E,F...; the wrap step uses Load (Count_in=E) with Count_en=0.
- Stop after 2 steps in mode 00 (Lo=0, Hi=9) -> no Count_en while in HOLD, Busy=1. Start resumes and the next step arrives after the remaining prescaler count. Start and Stop high together -> stays in HOLD.
- Start with Lo=7, Hi=3 -> Err=1, no Load, state IDLE. Reset asserted mid-RUN -> all outputs return to reset values asynchronously.
